// File: rtl/arb_defs.sv
// Shared definitions for the four-way bus arbiter: requester count,
// select width and FSM state encodings.
package arb_defs;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/selector41.sv
// Four-input data selector; {iS1,iS0} picks one of iC0..iC3 onto oZ.
module selector41 #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] iC0,
    input  logic [DATA_W-1:0] iC1,
    input  logic [DATA_W-1:0] iC2,
    input  logic [DATA_W-1:0] iC3,
    input  logic              iS1,
    input  logic              iS0,
    output logic [DATA_W-1:0] oZ
);

    always_comb begin
        oZ = iC0;
        case ({iS1, iS0})
            2'b00:   oZ = iC0;
            2'b01:   oZ = iC1;
            2'b10:   oZ = iC2;
            default: oZ = iC3;
        endcase
    end

endmodule

// File: rtl/bus_arbiter41.sv
// Round-robin arbiter/sequencer for a shared four-input selector: locks one
// owner per multi-beat transaction, with a stall watchdog forcing release.
module bus_arbiter41
    import arb_defs::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic [3:0]        iReq,
    input  logic [3:0]        iLast,
    input  logic [DATA_W-1:0] iC0,
    input  logic [DATA_W-1:0] iC1,
    input  logic [DATA_W-1:0] iC2,
    input  logic [DATA_W-1:0] iC3,
    input  logic              iReady,
    output logic              oValid,
    output logic [DATA_W-1:0] oZ,
    output logic [3:0]        oGnt,
    output logic              oS1,
    output logic              oS0,
    output logic              oBusy,
    output logic              oTimeout
);

    localparam int STALL_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit WDOG_EN = (TIMEOUT != 0);

    arb_state_t              state_q;
    logic [SEL_W-1:0]        ptr_q;
    logic [SEL_W-1:0]        own_q;
    logic [STALL_W-1:0]      stall_q;
    logic [NUM_REQ-1:0]      gnt_q;
    logic                    timeout_q;

    logic [SEL_W-1:0]        winner;
    logic                    xfer;
    logic                    wdog_hit;

    // First set request scanning ptr, ptr+1, ... (mod 4); lowest offset wins.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [SEL_W-1:0]   ptr);
        logic [SEL_W-1:0] idx;
        rr_pick = ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = ptr + SEL_W'(i);
            if (req[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

    assign winner   = rr_pick(iReq, ptr_q);
    assign oValid   = (state_q == ST_GRANT) && iReq[own_q];
    assign xfer     = oValid && iReady;
    assign wdog_hit = WDOG_EN && ((stall_q + STALL_W'(1)) == STALL_W'(TIMEOUT));

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            own_q     <= '0;
            stall_q   <= '0;
            gnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|iReq) begin
                        state_q <= ST_GRANT;
                        own_q   <= winner;
                        gnt_q   <= NUM_REQ'(1) << winner;
                        stall_q <= '0;
                    end
                end
                ST_GRANT: begin
                    if (xfer) begin
                        stall_q <= '0;
                        if (iLast[own_q]) begin
                            state_q <= ST_IDLE;
                            ptr_q   <= own_q + SEL_W'(1);
                            gnt_q   <= '0;
                        end
                    end else if (wdog_hit) begin
                        state_q   <= ST_IDLE;
                        ptr_q     <= own_q + SEL_W'(1);
                        gnt_q     <= '0;
                        timeout_q <= 1'b1;
                    end else if (WDOG_EN) begin
                        stall_q <= stall_q + STALL_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Select lines follow the owner and keep their value after release.
    assign oGnt     = gnt_q;
    assign {oS1, oS0} = own_q;
    assign oBusy    = (state_q == ST_GRANT);
    assign oTimeout = timeout_q;

    selector41 #(
        .DATA_W(DATA_W)
    ) u_sel (
        .iC0 (iC0),
        .iC1 (iC1),
        .iC2 (iC2),
        .iC3 (iC3),
        .iS1 (oS1),
        .iS0 (oS0),
        .oZ  (oZ)
    );

endmodule

// File: tb/tb_bus_arbiter41.sv
// Directed bench for bus_arbiter41: stimulus queues expected grants, beats and
// watchdog pulses; a negedge monitor pops and compares them as they appear.
module tb_bus_arbiter41;

    localparam logic [31:0] C0 = 32'hA000_0000;
    localparam logic [31:0] C1 = 32'hA111_1111;
    localparam logic [31:0] C2 = 32'hA222_2222;
    localparam logic [31:0] C3 = 32'hA333_3333;
    localparam logic [31:0] B1 = 32'hB000_0001;
    localparam logic [31:0] B2 = 32'hB000_0002;
    localparam logic [31:0] B3 = 32'hB000_0003;

    logic        iClk = 1'b0;
    logic        iRst_n = 1'b0;
    logic [3:0]  iReq = '0;
    logic [3:0]  iLast = '0;
    logic [31:0] iC0 = C0, iC1 = C1, iC2 = C2, iC3 = C3;
    logic        iReady = 1'b0;
    logic        oValid;
    logic [31:0] oZ;
    logic [3:0]  oGnt;
    logic        oS1, oS0, oBusy, oTimeout;

    typedef struct packed {
        logic [1:0]  idx;
        logic [31:0] data;
    } xfer_t;

    int    gnt_q[$];
    xfer_t xfer_q[$];
    int    to_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    logic [3:0] prev_gnt = '0;
    int    mon_e;
    xfer_t mon_x;

    bus_arbiter41 #(.DATA_W(32), .TIMEOUT(4)) dut (
        .iClk(iClk), .iRst_n(iRst_n), .iReq(iReq), .iLast(iLast),
        .iC0(iC0), .iC1(iC1), .iC2(iC2), .iC3(iC3), .iReady(iReady),
        .oValid(oValid), .oZ(oZ), .oGnt(oGnt), .oS1(oS1), .oS0(oS0),
        .oBusy(oBusy), .oTimeout(oTimeout)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge iClk);
        #1;
    endtask

    task automatic push_x(input logic [1:0] i, input logic [31:0] d);
        xfer_t x;
        x.idx  = i;
        x.data = d;
        xfer_q.push_back(x);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_gnt"}, 32'(oGnt), 32'h0);
        chk({tag, "_sel"}, 32'({oS1, oS0}), 32'h0);
        chk({tag, "_busy"}, 32'(oBusy), 32'h0);
        chk({tag, "_timeout"}, 32'(oTimeout), 32'h0);
        chk({tag, "_valid"}, 32'(oValid), 32'h0);
    endtask

    // Monitor: new grant (after an all-zero cycle), transfer beats, watchdog pulses.
    always @(negedge iClk) begin
        if (!iRst_n) begin
            prev_gnt = '0;
        end else begin
            if (oGnt != 4'b0000 && prev_gnt == 4'b0000) begin
                if (gnt_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL grant_unexpected: got oGnt=%b required no grant", oGnt);
                end else begin
                    mon_e = gnt_q.pop_front();
                    chk("grant_onehot", 32'(oGnt), 32'(1) << mon_e);
                    chk("grant_sel", 32'({oS1, oS0}), 32'(mon_e));
                end
            end
            if (oValid && iReady) begin
                if (xfer_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL xfer_unexpected: got oZ=%h required no transfer", oZ);
                end else begin
                    mon_x = xfer_q.pop_front();
                    chk("xfer_sel", 32'({oS1, oS0}), 32'(mon_x.idx));
                    chk("xfer_data", oZ, mon_x.data);
                end
            end
            if (oTimeout) begin
                if (to_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL timeout_unexpected: got oTimeout=1 required 0");
                end else begin
                    mon_e = to_q.pop_front();
                    chk("timeout_owner", 32'({oS1, oS0}), 32'(mon_e));
                end
            end
            prev_gnt = oGnt;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: got no finish required finish");
        $fatal(1, "time limit");
    end

    initial begin
        // Reset state
        #2;
        chk_reset_outputs("reset");
        @(posedge iClk); #1;
        iRst_n = 1'b1;
        step(1);

        // Round robin from 0: 1010 -> req1, then ptr=2 -> req3
        gnt_q.push_back(1); gnt_q.push_back(3);
        push_x(2'd1, C1); push_x(2'd3, C3);
        iReq = 4'b1010; iLast = 4'b1010; iReady = 1'b1;
        step(4);
        iReq = 4'b0000;
        step(2);

        // All four requesting single-beat: 0,1,2,3,0
        gnt_q.push_back(0); gnt_q.push_back(1); gnt_q.push_back(2);
        gnt_q.push_back(3); gnt_q.push_back(0);
        push_x(2'd0, C0); push_x(2'd1, C1); push_x(2'd2, C2);
        push_x(2'd3, C3); push_x(2'd0, C0);
        iReq = 4'b1111; iLast = 4'b1111;
        step(10);
        iReq = 4'b0000;
        step(2);

        // Requester 2, three beats, iReady 1,0,1,0,1
        gnt_q.push_back(2);
        push_x(2'd2, B1); push_x(2'd2, B2); push_x(2'd2, B3);
        iLast = 4'b0000; iReq = 4'b0100; iReady = 1'b1; iC2 = B1;
        step(1);
        chk("multi_gnt_b1", 32'(oGnt), 32'h4);
        step(1);
        chk("multi_gnt_s1", 32'(oGnt), 32'h4);
        iReady = 1'b0; iC2 = B2;
        step(1);
        chk("multi_gnt_b2", 32'(oGnt), 32'h4);
        iReady = 1'b1;
        step(1);
        chk("multi_gnt_s2", 32'(oGnt), 32'h4);
        iReady = 1'b0; iC2 = B3; iLast = 4'b0100;
        step(1);
        chk("multi_gnt_b3", 32'(oGnt), 32'h4);
        iReady = 1'b1;
        step(1);
        chk("multi_released_gnt", 32'(oGnt), 32'h0);
        chk("multi_released_busy", 32'(oBusy), 32'h0);
        iReq = 4'b0000; iC2 = C2; iLast = 4'b0000;
        step(1);

        // Watchdog: owner 0 stalls 4 cycles, requester 1 follows
        gnt_q.push_back(0); gnt_q.push_back(1);
        push_x(2'd1, C1);
        to_q.push_back(0);
        iReq = 4'b0011; iLast = 4'b0011; iReady = 1'b0;
        step(1);
        chk("wd_pre_timeout0", 32'(oTimeout), 32'h0);
        step(3);
        chk("wd_stall3_gnt", 32'(oGnt), 32'h1);
        chk("wd_stall3_timeout", 32'(oTimeout), 32'h0);
        step(1);
        chk("wd_fire_timeout", 32'(oTimeout), 32'h1);
        chk("wd_fire_gnt", 32'(oGnt), 32'h0);
        iReady = 1'b1;
        step(1);
        chk("wd_pulse_end", 32'(oTimeout), 32'h0);
        chk("wd_next_gnt", 32'(oGnt), 32'h2);
        step(1);
        iReq = 4'b0000; iReady = 1'b0;
        step(1);

        // Transfer with iLast on the watchdog-limit cycle: normal release
        gnt_q.push_back(0);
        push_x(2'd0, C0);
        iReq = 4'b0001; iLast = 4'b0001; iReady = 1'b0;
        step(4);
        iReady = 1'b1;
        step(1);
        chk("wd_last_timeout", 32'(oTimeout), 32'h0);
        chk("wd_last_gnt", 32'(oGnt), 32'h0);
        iReq = 4'b0000; iReady = 1'b0;
        step(2);

        // Asynchronous reset mid-transaction with owner 3
        iReq = 4'b1000; iLast = 4'b0000;
        step(1);
        chk("rst_owner3_gnt", 32'(oGnt), 32'h8);
        chk("rst_owner3_busy", 32'(oBusy), 32'h1);
        #2;
        iRst_n = 1'b0; iReq = 4'b1001;
        #1;
        chk_reset_outputs("async_rst");
        step(1);
        chk("rst_held_gnt", 32'(oGnt), 32'h0);
        iRst_n = 1'b1;
        gnt_q.push_back(0);
        push_x(2'd0, C0);
        iReady = 1'b1; iLast = 4'b1001;
        step(1);
        chk("post_rst_gnt", 32'(oGnt), 32'h1);
        step(1);
        iReq = 4'b0000; iReady = 1'b0;
        step(2);

        chk("grant_queue_drained", 32'(gnt_q.size()), 32'h0);
        chk("xfer_queue_drained", 32'(xfer_q.size()), 32'h0);
        chk("timeout_queue_drained", 32'(to_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
